// File: rtl/eca_mul_pkg.sv
// Shared types, sizes and the error-configurable adder cell for the iterative multiplier.
package eca_mul_pkg;

   localparam int WIDTH  = 8;
   localparam int PROD_W = 2 * WIDTH;
   localparam int CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Returns {cout, sum}; m=1 is a full adder, m=0 the cheaper approximate cell.
   function automatic logic [1:0] eca_cell_f(input logic x_i, input logic y_i,
                                             input logic c_i, input logic m_i);
      logic x;
      logic s;
      logic co;
      x = x_i ^ y_i;
      if (m_i) begin
         s  = x ^ c_i;
         co = (x_i & y_i) | (c_i & (x_i | y_i));
      end else begin
         s  = x | c_i;
         co = x_i & (y_i | c_i);
      end
      return {co, s};
   endfunction

endpackage

// File: rtl/eca_adder_row.sv
// Combinational ripple row of error-configurable adder cells; final carry is dropped.
module eca_adder_row
   import eca_mul_pkg::*;
#(
   parameter int PROD_W = 16
) (
   input  logic [PROD_W-1:0] x,
   input  logic [PROD_W-1:0] y,
   input  logic [PROD_W-1:0] m,
   output logic [PROD_W-1:0] s
);

   logic c;

   always_comb begin
      s = '0;
      c = 1'b0;
      for (int j = 0; j < PROD_W; j++) begin
         {c, s[j]} = eca_cell_f(x[j], y[j], c, m[j]);
      end
   end

endmodule

// File: rtl/eca_iterative_multiplier.sv
// Shift-add multiplier, one partial product per cycle through an approximate adder row.
// Optional ECA_MUL_EARLY_EXIT_EN: leave RUN once no multiplier bits remain.
module eca_iterative_multiplier
   import eca_mul_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   Operand_1,
   input  logic [WIDTH-1:0]   Operand_2,
   input  logic [2*WIDTH-1:0] u,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] Result
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_e          state_q, state_d;
   logic            in_ready_q, in_ready_d;
   logic            out_valid_q, out_valid_d;
   logic [PW-1:0]   result_q, result_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [PW-1:0]   u_q, u_d;
   logic [PW-1:0]   acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [PW-1:0]   addend;
   logic [PW-1:0]   row_sum;
   logic            run_last;

   assign addend = b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;

`ifdef ECA_MUL_EARLY_EXIT_EN
   assign run_last = (cnt_q == CW'(WIDTH - 1)) || (((b_q >> cnt_q) >> 1) == '0);
`else
   assign run_last = (cnt_q == CW'(WIDTH - 1));
`endif

   eca_adder_row #(.PROD_W(PW)) u_row (
      .x (acc_q),
      .y (addend),
      .m (u_q),
      .s (row_sum)
   );

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      a_d         = a_q;
      b_d         = b_q;
      u_d         = u_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               a_d     = Operand_1;
               b_d     = Operand_2;
               u_d     = u;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d = row_sum;
            cnt_d = cnt_q + 1'b1;
            if (run_last) state_d = DONE;
         end
         DONE: begin
            // Result is published one cycle after the last step and then frozen until taken.
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               result_d    = acc_q;
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         a_q         <= '0;
         b_q         <= '0;
         u_q         <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         a_q         <= a_d;
         b_q         <= b_d;
         u_q         <= u_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign Result    = result_q;

endmodule
